shift55i24o: RTL and testbench

- Inverse of the codebase's 24-to-55-bit left shifter.
- Takes a signed 55-bit wide-accumulator value and divides it by 2^n, n = 0..31, using arithmetic right shifts.
- Rounds, saturates to a signed 24-bit result, and flags overflow.
- Sits at the output of CIC/accumulator stages to return data to the 24-bit sample path. Fully pipelined, one sample per clock, with a valid strobe.

---
 rtl/dsp_pkg.sv | 16 +
 rtl/shift55i24o_round_sat.sv | 39 +++
 rtl/shift55i24o.sv | 116 +++++++++++
 tb/tb_shift55i24o.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared widths and saturation limits for the accumulator-to-sample
// width-reduction blocks.
package dsp_pkg;

  localparam int DW_WIDE = 55;
  localparam int DW_SAMP = 24;

  // Wide value plus one appended round bit below the LSB.
  localparam int DW_EXT  = DW_WIDE + 1;

  localparam logic [DW_SAMP-1:0] SAT_POS = 24'h7FFFFF;
  localparam logic [DW_SAMP-1:0] SAT_NEG = 24'h800000;

  typedef logic signed [DW_EXT-1:0] ext_t;

endpackage

// File: rtl/shift55i24o_round_sat.sv
// Combinational round-and-saturate: takes a 56-bit value whose LSB is the
// round bit, optionally rounds half up, and clamps to a signed 24-bit sample.
module round_sat
  import dsp_pkg::*;
#(
  parameter bit RND = 1'b1
) (
  input  ext_t               x_i,
  output logic [DW_SAMP-1:0] q_o,
  output logic               ovf_o
);

  localparam ext_t MAX_VAL = ext_t'(56'sd8388607);
  localparam ext_t MIN_VAL = -ext_t'(56'sd8388608);

  ext_t rndBit;
  ext_t r;

  // Drop the round bit, add it back when rounding, then clamp to 24 bits.
  // r is kept at the full 56 bits so the +1 can never wrap.
  always_comb begin
    rndBit = '0;
    if (RND) begin
      rndBit = ext_t'({{(DW_EXT-1){1'b0}}, x_i[0]});
    end
    r = (x_i >>> 1) + rndBit;
    if (r > MAX_VAL) begin
      q_o   = SAT_POS;
      ovf_o = 1'b1;
    end else if (r < MIN_VAL) begin
      q_o   = SAT_NEG;
      ovf_o = 1'b1;
    end else begin
      q_o   = r[DW_SAMP-1:0];
      ovf_o = 1'b0;
    end
  end

endmodule

// File: rtl/shift55i24o.sv
// 55-bit to 24-bit arithmetic right shifter (divide by 2^n, n = 0..31)
// with rounding, saturation and a sticky overflow flag. Four-stage
// pipeline, one sample per clock; n travels alongside its own sample.
module shift55i24o
  import dsp_pkg::*;
#(
  parameter bit RND = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [DW_WIDE-1:0] d,
  input  logic        [4:0]         n,
  input  logic                      vi,
  input  logic                      clr,
  output logic        [DW_SAMP-1:0] q,
  output logic                      vo,
  output logic                      ovf,
  output logic                      ovf_hold
);

  ext_t       s1X_d, s1X_q;
  logic [3:0] s1N_q;
  logic       s1Sign_q;
  logic       v1_q;

  ext_t       s2X_d, s2X_q;
  logic [1:0] s2N_q;
  logic       s2Sign_q;
  logic       v2_q;

  ext_t       s3X_d, s3X_q;
  logic       v3_q;

  logic [DW_SAMP-1:0] satQ;
  logic               satOvf;
  logic               ovfHold_d;

  // Stage 1 shift: append the round bit, then coarse shift by 16 on n[4].
  always_comb begin
    s1X_d = {d, 1'b0};
    if (n[4]) begin
      s1X_d = {{16{d[DW_WIDE-1]}}, d, 1'b0} >>> 0;
      s1X_d = ext_t'({{16{d[DW_WIDE-1]}}, d[DW_WIDE-1:15]});
    end
  end

  // Stage 2 shift: 0/4/8/12 positions, filled with the carried sign.
  always_comb begin
    unique case (s1N_q[3:2])
      2'd0:    s2X_d = s1X_q;
      2'd1:    s2X_d = {{4{s1Sign_q}},  s1X_q[DW_EXT-1:4]};
      2'd2:    s2X_d = {{8{s1Sign_q}},  s1X_q[DW_EXT-1:8]};
      default: s2X_d = {{12{s1Sign_q}}, s1X_q[DW_EXT-1:12]};
    endcase
  end

  // Stage 3 shift: 0/1/2/3 positions, filled with the carried sign.
  always_comb begin
    unique case (s2N_q)
      2'd0:    s3X_d = s2X_q;
      2'd1:    s3X_d = {{1{s2Sign_q}}, s2X_q[DW_EXT-1:1]};
      2'd2:    s3X_d = {{2{s2Sign_q}}, s2X_q[DW_EXT-1:2]};
      default: s3X_d = {{3{s2Sign_q}}, s2X_q[DW_EXT-1:3]};
    endcase
  end

  round_sat #(
    .RND (RND)
  ) u_roundSat (
    .x_i   (s3X_q),
    .q_o   (satQ),
    .ovf_o (satOvf)
  );

  // Sticky flag rises together with an overflowing output and also holds
  // through the clock where that output is visible, so a coincident clr loses.
  always_comb begin
    ovfHold_d = (v3_q & satOvf) | (vo & ovf) | (ovf_hold & ~clr);
  end

  // Pipeline registers: data loads every clock, valid tracks vi exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1X_q    <= '0;
      s1N_q    <= '0;
      s1Sign_q <= 1'b0;
      v1_q     <= 1'b0;
      s2X_q    <= '0;
      s2N_q    <= '0;
      s2Sign_q <= 1'b0;
      v2_q     <= 1'b0;
      s3X_q    <= '0;
      v3_q     <= 1'b0;
      q        <= '0;
      ovf      <= 1'b0;
      vo       <= 1'b0;
      ovf_hold <= 1'b0;
    end else begin
      s1X_q    <= s1X_d;
      s1N_q    <= n[3:0];
      s1Sign_q <= d[DW_WIDE-1];
      v1_q     <= vi;
      s2X_q    <= s2X_d;
      s2N_q    <= s1N_q[1:0];
      s2Sign_q <= s1Sign_q;
      v2_q     <= v1_q;
      s3X_q    <= s3X_d;
      v3_q     <= v2_q;
      q        <= satQ;
      ovf      <= satOvf;
      vo       <= v3_q;
      ovf_hold <= ovfHold_d;
    end
  end

endmodule

// File: tb/tb_shift55i24o.sv
// Bench for shift55i24o: two instances (round-half-up and truncate) share
// stimulus; directed vector table, random back-to-back stream against a
// reference divider, and hand-written clr/reset/valid sequences.
module tb_shift55i24o;

  logic               clk;
  logic               rst_n;
  logic signed [54:0] d;
  logic        [4:0]  n;
  logic               vi;
  logic               clr;

  logic [23:0] q1, q0;
  logic        vo1, vo0, ovf1, ovf0, hold1, hold0;

  int passCount  = 0;
  int checkCount = 0;

  shift55i24o #(.RND(1'b1)) dutRnd (
    .clk(clk), .rst_n(rst_n), .d(d), .n(n), .vi(vi), .clr(clr),
    .q(q1), .vo(vo1), .ovf(ovf1), .ovf_hold(hold1)
  );

  shift55i24o #(.RND(1'b0)) dutTrn (
    .clk(clk), .rst_n(rst_n), .d(d), .n(n), .vi(vi), .clr(clr),
    .q(q0), .vo(vo0), .ovf(ovf0), .ovf_hold(hold0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic signed [54:0] d;
    logic [4:0]         n;
    logic [23:0]        q1;
    logic               ovf1;
    logic [23:0]        q0;
    logic               ovf0;
  } vec_t;

  vec_t vecs[15];

  // Independent reference: floor(d / 2^n), plus the bit just below the
  // binary point when rounding half up, then clamp to signed 24 bits.
  function automatic logic [24:0] refModel(logic signed [54:0] dv, int nv, bit rnd);
    logic signed [55:0] t;
    t = dv;
    t = t >>> nv;
    if (rnd && nv > 0) t = t + 56'(dv[nv-1]);
    if (t > 56'sd8388607)       return {1'b1, 24'h7FFFFF};
    else if (t < -56'sd8388608) return {1'b1, 24'h800000};
    else                        return {1'b0, t[23:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic signed [54:0] dv, input logic [4:0] nv);
    vi = v;
    d  = dv;
    n  = nv;
  endtask

  logic signed [54:0] rd[40];
  logic [4:0]         rn[40];
  logic [63:0]        tmp;
  bit                 pat[5];

  initial begin
    vecs[0]  = '{55'sd256,        5'd4,  24'd16,     1'b0, 24'd16,     1'b0};
    vecs[1]  = '{55'sd24,         5'd4,  24'd2,      1'b0, 24'd1,      1'b0};
    vecs[2]  = '{-55'sd24,        5'd4,  24'hFFFFFF, 1'b0, 24'hFFFFFE, 1'b0};
    vecs[3]  = '{-55'sd8,         5'd4,  24'd0,      1'b0, 24'hFFFFFF, 1'b0};
    vecs[4]  = '{55'sd1073741824, 5'd0,  24'h7FFFFF, 1'b1, 24'h7FFFFF, 1'b1};
    vecs[5]  = '{-55'sd1073741824,5'd6,  24'h800000, 1'b1, 24'h800000, 1'b1};
    vecs[6]  = '{55'sd1073741824, 5'd7,  24'h7FFFFF, 1'b1, 24'h7FFFFF, 1'b1};
    vecs[7]  = '{-55'sd1,         5'd31, 24'd0,      1'b0, 24'hFFFFFF, 1'b0};
    vecs[8]  = '{{1'b1, 54'd0},   5'd31, 24'h800000, 1'b0, 24'h800000, 1'b0};
    vecs[9]  = '{{1'b0, {54{1'b1}}}, 5'd31, 24'h7FFFFF, 1'b1, 24'h7FFFFF, 1'b0};
    vecs[10] = '{55'sd8388608,    5'd0,  24'h7FFFFF, 1'b1, 24'h7FFFFF, 1'b1};
    vecs[11] = '{55'sd8388607,    5'd0,  24'h7FFFFF, 1'b0, 24'h7FFFFF, 1'b0};
    vecs[12] = '{-55'sd8388608,   5'd0,  24'h800000, 1'b0, 24'h800000, 1'b0};
    vecs[13] = '{55'sd3,          5'd1,  24'd2,      1'b0, 24'd1,      1'b0};
    vecs[14] = '{-55'sd7,         5'd2,  24'hFFFFFE, 1'b0, 24'hFFFFFE, 1'b0};

    rst_n = 1'b0;
    clr   = 1'b0;
    applyStimulus(1'b0, '0, '0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset vo",   {62'd0, vo1, vo0},     64'd0);
    checkOutput("reset q",    {16'd0, q1, q0},       64'd0);
    checkOutput("reset ovf",  {62'd0, ovf1, ovf0},   64'd0);
    checkOutput("reset hold", {62'd0, hold1, hold0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, streamed back-to-back; vector i emerges 4 clocks later
    for (int i = 0; i < 15 + 4; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        checkOutput($sformatf("vec%0d vo", i-4),     {62'd0, vo1, vo0}, 64'd3);
        checkOutput($sformatf("vec%0d q rnd", i-4),  64'(q1),   64'(vecs[i-4].q1));
        checkOutput($sformatf("vec%0d ovf rnd", i-4),64'(ovf1), 64'(vecs[i-4].ovf1));
        checkOutput($sformatf("vec%0d q trn", i-4),  64'(q0),   64'(vecs[i-4].q0));
        checkOutput($sformatf("vec%0d ovf trn", i-4),64'(ovf0), 64'(vecs[i-4].ovf0));
      end
      if (i < 15) applyStimulus(1'b1, vecs[i].d, vecs[i].n);
      else        applyStimulus(1'b0, '0, '0);
    end

    // Sticky flag set, then cleared by a clr pulse
    @(negedge clk);
    checkOutput("hold after ovf", {62'd0, hold1, hold0}, 64'd3);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("hold after clr", {62'd0, hold1, hold0}, 64'd0);

    // clr held across an overflowing output: set wins on that clock
    clr = 1'b1;
    applyStimulus(1'b1, 55'sd1073741824, 5'd0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("coinc ovf", {62'd0, ovf1, ovf0}, 64'd3);
    checkOutput("coinc hold rise", {62'd0, hold1, hold0}, 64'd3);
    @(negedge clk);
    checkOutput("coinc hold kept", {62'd0, hold1, hold0}, 64'd3);
    @(negedge clk);
    checkOutput("coinc hold cleared", {62'd0, hold1, hold0}, 64'd0);
    clr = 1'b0;

    // Random back-to-back stream, n changing every clock
    for (int i = 0; i < 40; i++) begin
      tmp   = {$urandom, $urandom};
      rd[i] = $signed(tmp[54:0]) >>> $urandom_range(0, 32);
      case (i)
        0: rn[i] = 5'd0;   1: rn[i] = 5'd31;  2: rn[i] = 5'd5;
        3: rn[i] = 5'd16;  4: rn[i] = 5'd1;   5: rn[i] = 5'd30;
        default: rn[i] = 5'($urandom_range(0, 31));
      endcase
    end
    for (int i = 0; i < 40 + 4; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        checkOutput($sformatf("rand%0d vo", i-4), {62'd0, vo1, vo0}, 64'd3);
        checkOutput($sformatf("rand%0d rnd", i-4), {39'd0, ovf1, q1}, 64'(refModel(rd[i-4], int'(rn[i-4]), 1'b1)));
        checkOutput($sformatf("rand%0d trn", i-4), {39'd0, ovf0, q0}, 64'(refModel(rd[i-4], int'(rn[i-4]), 1'b0)));
      end
      if (i < 40) applyStimulus(1'b1, rd[i], rn[i]);
      else        applyStimulus(1'b0, '0, '0);
    end

    // Reset while samples are in flight
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(1'b1, 55'sd1073741824, 5'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, '0);
    end
    checkOutput("pre-reset hold", {62'd0, hold1, hold0}, 64'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 55'sd256, 5'd4);
      @(negedge clk);
    end
    applyStimulus(1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst vo",   {62'd0, vo1, vo0},     64'd0);
    checkOutput("midrst q",    {16'd0, q1, q0},       64'd0);
    checkOutput("midrst hold", {62'd0, hold1, hold0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 55'sd24, 5'd4);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, '0);
      if (i < 4) checkOutput($sformatf("postrst idle%0d vo", i), {62'd0, vo1, vo0}, 64'd0);
    end
    checkOutput("postrst vo", {62'd0, vo1, vo0}, 64'd3);
    checkOutput("postrst q",  {16'd0, q1, q0},   {40'd0, 24'd2, 24'd1});

    // vi pattern 1,0,1,1,0 reproduced on vo 4 clocks later
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i >= 4) checkOutput($sformatf("pattern%0d vo", i-4), {62'd0, vo1, vo0}, pat[i-4] ? 64'd3 : 64'd0);
      if (i < 5) applyStimulus(pat[i], 55'sd256, 5'd4);
      else       applyStimulus(1'b0, '0, '0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
